alu_sched: RTL and testbench

Two-port scheduler for the shared single-cycle ALU. It arbitrates between two requesters, the execute stage (port 0) and the address/auxiliary unit (port 1), and drives the ALU operand, opcode and shift inputs for the granted requester. It captures the ALU result in a per-port response register with valid/ready backpressure. It sits between the ALU and its two clients, which no longer drive the ALU directly.

---
 rtl/alu_sched.sv | 119 +++++++++++
 tb/tb_alu_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-port scheduler for the shared single-cycle ALU with per-port registered responses.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise port 0 wins every tie.
module alu_sched #(
   parameter int unsigned W    = 32,
   parameter int unsigned OPW  = 3,
   parameter int unsigned SHW  = 4,
   parameter int unsigned CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [W-1:0]    req0_sr1,
   input  logic [W-1:0]    req0_sr2,
   input  logic [OPW-1:0]  req0_os,
   input  logic [SHW-1:0]  req0_shift,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic [W-1:0]    rsp0_rd,
   output logic            rsp0_zero,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [W-1:0]    req1_sr1,
   input  logic [W-1:0]    req1_sr2,
   input  logic [OPW-1:0]  req1_os,
   input  logic [SHW-1:0]  req1_shift,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [W-1:0]    rsp1_rd,
   output logic            rsp1_zero,
   output logic [W-1:0]    alu_sr1,
   output logic [W-1:0]    alu_sr2,
   output logic [OPW-1:0]  alu_os,
   output logic [SHW-1:0]  alu_shift,
   input  logic [W-1:0]    alu_rd,
   output logic [CNTW-1:0] op_cnt
);

   logic free0, free1, elig0, elig1, grant0, grant1;
   logic alu_zero;

   // A held result blocks its port unless it is being drained this cycle.
   assign free0 = !rsp0_valid || rsp0_ready;
   assign free1 = !rsp1_valid || rsp1_ready;
   assign elig0 = req0_valid && free0 && !rst;
   assign elig1 = req1_valid && free1 && !rst;

`ifdef ALU_SCHED_RR_EN
   logic ptr;

   assign grant0 = elig0 && (!elig1 || !ptr);
   assign grant1 = elig1 && (!elig0 || ptr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (grant0 || grant1) begin
         ptr <= grant0;
      end
   end
`else
   assign grant0 = elig0;
   assign grant1 = elig1 && !elig0;
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_sr1   = '0;
      alu_sr2   = '0;
      alu_os    = '0;
      alu_shift = '0;
      if (grant0) begin
         alu_sr1   = req0_sr1;
         alu_sr2   = req0_sr2;
         alu_os    = req0_os;
         alu_shift = req0_shift;
      end else if (grant1) begin
         alu_sr1   = req1_sr1;
         alu_sr2   = req1_sr2;
         alu_os    = req1_os;
         alu_shift = req1_shift;
      end
   end

   assign alu_zero = (alu_rd == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp0_rd    <= '0;
         rsp0_zero  <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rd    <= '0;
         rsp1_zero  <= 1'b0;
         op_cnt     <= '0;
      end else begin
         if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_rd    <= alu_rd;
            rsp0_zero  <= alu_zero;
         end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_rd    <= alu_rd;
            rsp1_zero  <= alu_zero;
         end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end
         if (grant0 || grant1) begin
            op_cnt <= op_cnt + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed bench for alu_sched against a transaction-level reference model.
module tb_alu_sched;
   localparam int W    = 32;
   localparam int OPW  = 3;
   localparam int SHW  = 4;
   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] v, rr;
   logic [W-1:0] s1 [2];
   logic [W-1:0] s2 [2];
   logic [OPW-1:0] os [2];
   logic [SHW-1:0] sh [2];
   logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
   logic [W-1:0] rsp0_rd, rsp1_rd, alu_sr1, alu_sr2, alu_rd;
   logic [OPW-1:0] alu_os;
   logic [SHW-1:0] alu_shift;
   logic [CNTW-1:0] op_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit           m_valid [2];
   logic [W-1:0] m_rd    [2];
   bit           m_zero  [2];
   int           m_cnt;
   int           m_last;
   int           last_win;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OPW-1:0] o, input logic [SHW-1:0] s);
      case (o)
         3'd0:    return a + b;
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a ^ b;
         3'd4:    return a << s;
         3'd5:    return a >> s;
         3'd6:    return b;
         default: return a - b;
      endcase
   endfunction

   assign alu_rd = alu_f(alu_sr1, alu_sr2, alu_os, alu_shift);

   alu_sched #(.W(W), .OPW(OPW), .SHW(SHW), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v[0]),
      .req0_ready (req0_ready),
      .req0_sr1   (s1[0]),
      .req0_sr2   (s2[0]),
      .req0_os    (os[0]),
      .req0_shift (sh[0]),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rr[0]),
      .rsp0_rd    (rsp0_rd),
      .rsp0_zero  (rsp0_zero),
      .req1_valid (v[1]),
      .req1_ready (req1_ready),
      .req1_sr1   (s1[1]),
      .req1_sr2   (s2[1]),
      .req1_os    (os[1]),
      .req1_shift (sh[1]),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rr[1]),
      .rsp1_rd    (rsp1_rd),
      .rsp1_zero  (rsp1_zero),
      .alu_sr1    (alu_sr1),
      .alu_sr2    (alu_sr2),
      .alu_os     (alu_os),
      .alu_shift  (alu_shift),
      .alu_rd     (alu_rd),
      .op_cnt     (op_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_valid[p] = 1'b0;
         m_rd[p]    = '0;
         m_zero[p]  = 1'b0;
      end
      m_cnt  = 0;
      m_last = 1; // so port 0 wins the first tie
   endtask

   task automatic set_port(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OPW-1:0] o, input logic [SHW-1:0] s);
      s1[p] = a;
      s2[p] = b;
      os[p] = o;
      sh[p] = s;
   endtask

   // Called #1 after a rising edge with inputs already set; returns #1 after the next one.
   task automatic cycle();
      int w;
      bit el [2];
      logic [W-1:0] e_rd;
      @(negedge clk);
      for (int p = 0; p < 2; p++) el[p] = v[p] && (!m_valid[p] || rr[p]);
      if (el[0] && el[1]) begin
`ifdef ALU_SCHED_RR_EN
         w = (m_last == 0) ? 1 : 0;
`else
         w = 0;
`endif
      end else if (el[0]) w = 0;
      else if (el[1]) w = 1;
      else w = -1;
      check("req0_ready", req0_ready, (w == 0));
      check("req1_ready", req1_ready, (w == 1));
      e_rd = '0;
      if (w >= 0) begin
         check("alu_sr1", alu_sr1, s1[w]);
         check("alu_sr2", alu_sr2, s2[w]);
         check("alu_os", alu_os, os[w]);
         check("alu_shift", alu_shift, sh[w]);
         e_rd = alu_f(s1[w], s2[w], os[w], sh[w]);
      end else begin
         check("alu_idle", {alu_sr1, alu_sr2, alu_os, alu_shift}, 0);
      end
      last_win = w;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (p == w) begin
            m_valid[p] = 1'b1;
            m_rd[p]    = e_rd;
            m_zero[p]  = (e_rd == 0);
         end else if (rr[p]) begin
            m_valid[p] = 1'b0;
         end
      end
      if (w >= 0) begin
         m_cnt  = (m_cnt + 1) % (1 << CNTW);
         m_last = w;
      end
      check("rsp0_valid", rsp0_valid, m_valid[0]);
      check("rsp0_rd", rsp0_rd, m_rd[0]);
      check("rsp0_zero", rsp0_zero, m_zero[0]);
      check("rsp1_valid", rsp1_valid, m_valid[1]);
      check("rsp1_rd", rsp1_rd, m_rd[1]);
      check("rsp1_zero", rsp1_zero, m_zero[1]);
      check("op_cnt", op_cnt, m_cnt);
   endtask

   task automatic do_reset();
      v   = 2'b00;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      v   = 2'b11;
      rr  = 2'b11;
      for (int p = 0; p < 2; p++) set_port(p, 32'd1, 32'd2, 3'd0, 4'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp0_rd", rsp0_rd, 0);
      check("rst_op_cnt", op_cnt, 0);
      v   = 2'b00;
      rst = 1'b0;

      // Single add on port 0
      v = 2'b01;
      set_port(0, 32'd5, 32'd7, 3'd0, 4'd0);
      cycle();
      check("add_grant", last_win, 0);
      check("add_rd", rsp0_rd, 12);
      check("add_zero", rsp0_zero, 0);
      check("add_cnt", op_cnt, 1);

      // Both ports contending with both responses drained
      do_reset();
      v  = 2'b11;
      rr = 2'b11;
      for (int i = 0; i < 4; i++) begin
         set_port(0, $urandom, $urandom, 3'(i), 4'(i));
         set_port(1, $urandom, $urandom, 3'(i + 1), 4'(i + 3));
         cycle();
`ifdef ALU_SCHED_RR_EN
         check("alt_winner", last_win, i % 2);
`else
         check("fixed_winner", last_win, 0);
`endif
      end

      // Subtract to zero on port 1
      v = 2'b10;
      set_port(1, 32'd9, 32'd9, 3'b111, 4'd0);
      cycle();
      check("sub_rd", rsp1_rd, 0);
      check("sub_zero", rsp1_zero, 1);

      // Backpressure on port 0 while port 1 keeps going
      do_reset();
      v  = 2'b01;
      rr = 2'b11;
      set_port(0, 32'd100, 32'd23, 3'd0, 4'd0);
      cycle();
      rr = 2'b10;
      v  = 2'b11;
      for (int i = 0; i < 3; i++) begin
         set_port(0, $urandom, $urandom, 3'd0, 4'd0);
         set_port(1, $urandom, $urandom, 3'(i), 4'(i));
         cycle();
         check("bp_winner", last_win, 1);
         check("bp_hold_rd", rsp0_rd, 123);
      end
      rr = 2'b11;
      set_port(0, 32'd40, 32'd2, 3'd0, 4'd0);
      cycle();
      check("bp_release_winner", last_win, 0);
      check("bp_release_rd", rsp0_rd, 42);

      // Counter wrap after 2^CNTW grants
      do_reset();
      v  = 2'b01;
      rr = 2'b11;
      for (int i = 0; i < (1 << CNTW); i++) begin
         set_port(0, $urandom, $urandom, 3'($urandom), 4'($urandom));
         cycle();
      end
      check("wrap_cnt", op_cnt, 0);
      check("wrap_valid", rsp0_valid, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         v = 2'($urandom);
         rr[0] = ($urandom_range(3) != 0);
         rr[1] = ($urandom_range(3) != 0);
         for (int p = 0; p < 2; p++) begin
            s1[p] = $urandom;
            s2[p] = ($urandom_range(3) == 0) ? s1[p] : W'($urandom);
            os[p] = 3'($urandom);
            sh[p] = 4'($urandom);
         end
         cycle();
      end

      // Asynchronous reset while port 1 holds a result
      v  = 2'b10;
      rr = 2'b00;
      set_port(1, 32'd3, 32'd4, 3'd0, 4'd0);
      cycle();
      check("pre_rst_valid1", rsp1_valid, 1);
      v = 2'b00;
      #2;
      rst = 1'b1;
      #1;
      check("async_rsp1_valid", rsp1_valid, 0);
      check("async_rsp1_rd", rsp1_rd, 0);
      check("async_op_cnt", op_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
